ddt_frame_capture_writer: RTL and testbench

//  Parametrised DDT-to-SRAM frame writer: aligns capture to DDT frame starts, skips N frames after arming,

---
 rtl/ddt_frame_capture_writer.sv | 254 +++++++++++++++++++++++++
 tb/tb_ddt_frame_capture_writer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddt_frame_capture_writer.sv
// ---------------------------------------------------------------------------
// ddt_frame_capture_writer
//
// Purpose:
//   Captures DDT display frames into an external SRAM. Capture is aligned to
//   DDT frame starts. After arming, SKIP_FRAMES complete frames are thrown
//   away before capture begins. Pixels are written at line-strided word
//   addresses. Capture is either single-shot, or continuous with the two
//   halves of the SRAM used as ping-pong banks on alternate frames.
//
// Ports:
//   DDT_Clock    in   1          single clock, rising edge
//   Reset        in   1          synchronous, active-high
//   Arm          in   1          level request to capture
//   Continuous   in   1          1 = ping-pong capture every frame
//   DDT_VSA_Inv  in   1          inverted vsync, 1->0 marks a frame start
//   DDT_DE       in   1          data enable, high during active pixels
//   DDT_R/G/B    in   PIX_W      pixel colour channels
//   SRAM_Addr    out  ADDR_W     write address, MSB is the bank select
//   SRAM_Data    out  3*PIX_W    write data packed {B,G,R}
//   SRAM_WE_n    out  1          active-low write strobe, one cycle per pixel
//   SRAM_CE_n    out  1          active-low chip enable while not idle
//   Line_Cnt     out  16         lines completed in the captured frame
//   Bank         out  1          bank currently being written
//   Busy         out  1          block is armed or capturing
//   Frame_Done   out  1          one-cycle pulse when a captured frame closes
//   Overflow     out  1          sticky flag, set when a pixel is dropped
// ---------------------------------------------------------------------------
module ddt_frame_capture_writer #(
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 19,
  parameter int LINE_STRIDE = 1024,
  parameter int SKIP_FRAMES = 1
) (
  input  logic                 DDT_Clock,
  input  logic                 Reset,
  input  logic                 Arm,
  input  logic                 Continuous,
  input  logic                 DDT_VSA_Inv,
  input  logic                 DDT_DE,
  input  logic [PIX_W-1:0]     DDT_R,
  input  logic [PIX_W-1:0]     DDT_G,
  input  logic [PIX_W-1:0]     DDT_B,
  output logic [ADDR_W-1:0]    SRAM_Addr,
  output logic [3*PIX_W-1:0]   SRAM_Data,
  output logic                 SRAM_WE_n,
  output logic                 SRAM_CE_n,
  output logic [15:0]          Line_Cnt,
  output logic                 Bank,
  output logic                 Busy,
  output logic                 Frame_Done,
  output logic                 Overflow
);

  // The pixel counter needs one extra bit so that it can sit at LINE_STRIDE
  // once a line has overrun its reserved space.
  localparam int PIX_CW = $clog2(LINE_STRIDE) + 1;

  // Number of words in one bank. It is one bit wider than a bank offset,
  // so that an offset can be compared against the end of the bank.
  localparam logic [ADDR_W:0]   BANK_WORDS  = (ADDR_W + 1)'(1) << (ADDR_W - 1);
  localparam logic [PIX_CW-1:0] STRIDE_PIX  = PIX_CW'(LINE_STRIDE);
  localparam logic [ADDR_W-1:0] STRIDE_BASE = ADDR_W'(LINE_STRIDE);
  localparam logic [7:0]        SKIP_CNT    = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t               r_state;
  logic                 r_deD1;
  logic                 r_deD2;
  logic                 r_vsaD1;
  logic                 r_vsaD2;
  logic [3*PIX_W-1:0]   r_pixD1;

  logic [7:0]           r_skipCnt;
  logic                 r_bank;
  logic [15:0]          r_lineCnt;
  logic [ADDR_W-1:0]    r_lineBase;
  logic [PIX_CW-1:0]    r_pix;
  logic                 r_lineActive;
  logic                 r_frameDone;
  logic                 r_overflow;

  logic                 r_wrReq;
  logic [ADDR_W-1:0]    r_wrAddr;
  logic [3*PIX_W-1:0]   r_wrData;

  logic                 w_frameStart;
  logic                 w_lineStart;
  logic                 w_lineEnd;
  logic [ADDR_W:0]      w_pixAddr;
  logic                 w_pixValid;
  logic                 w_pixFits;
  logic                 w_doWrite;
  logic                 w_baseInBank;

  // Input stage: register the DDT pins. Vsync gets a second stage so that
  // its falling edge can be found. Data enable gets a second stage so that
  // line starts and line ends can be found.
  always_ff @(posedge DDT_Clock) begin
    if (Reset) begin
      r_deD1  <= 1'b0;
      r_deD2  <= 1'b0;
      r_vsaD1 <= 1'b0;
      r_vsaD2 <= 1'b0;
      r_pixD1 <= '0;
    end else begin
      r_deD1  <= DDT_DE;
      r_deD2  <= r_deD1;
      r_vsaD1 <= DDT_VSA_Inv;
      r_vsaD2 <= r_vsaD1;
      r_pixD1 <= {DDT_B, DDT_G, DDT_R};
    end
  end

  // Edge detection on the registered DDT timing signals.
  assign w_frameStart = r_vsaD2 & ~r_vsaD1;
  assign w_lineStart  = r_deD1 & ~r_deD2;
  assign w_lineEnd    = ~r_deD1 & r_deD2;

  // Offset of the current pixel within the bank. This is kept wide so that
  // running past the end of the bank is visible instead of wrapping.
  assign w_pixAddr = {1'b0, r_lineBase} + {{(ADDR_W + 1 - PIX_CW){1'b0}}, r_pix};

  // A pixel is eligible only if its line began while capturing. A frame
  // start takes priority over any pixel on the same cycle.
  assign w_pixValid   = (r_state == ST_CAPTURE) & r_deD1 & (w_lineStart | r_lineActive)
                        & ~w_frameStart;
  assign w_pixFits    = (r_pix < STRIDE_PIX) & (w_pixAddr < BANK_WORDS);
  assign w_doWrite    = w_pixValid & w_pixFits;
  assign w_baseInBank = ({1'b0, r_lineBase} < BANK_WORDS);

  // Control FSM and address generation.
  // WAIT counts frame starts until the skip count is used up.
  // CAPTURE tracks the line base, the pixel index and the line count.
  // A write request produced here is presented on the SRAM pins one cycle
  // later.
  always_ff @(posedge DDT_Clock) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_skipCnt    <= '0;
      r_bank       <= 1'b0;
      r_lineCnt    <= '0;
      r_lineBase   <= '0;
      r_pix        <= '0;
      r_lineActive <= 1'b0;
      r_frameDone  <= 1'b0;
      r_overflow   <= 1'b0;
      r_wrReq      <= 1'b0;
      r_wrAddr     <= '0;
      r_wrData     <= '0;
    end else begin
      r_frameDone <= 1'b0;
      r_wrReq     <= 1'b0;

      if (w_doWrite) begin
        r_wrReq  <= 1'b1;
        r_wrAddr <= {r_bank, w_pixAddr[ADDR_W-2:0]};
        r_wrData <= r_pixD1;
      end

      case (r_state)
        ST_IDLE: begin
          if (Arm) begin
            r_state    <= ST_WAIT;
            r_skipCnt  <= '0;
            r_overflow <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (!Arm) begin
            r_state <= ST_IDLE;
          end else if (w_frameStart) begin
            if (r_skipCnt == SKIP_CNT) begin
              r_state      <= ST_CAPTURE;
              r_bank       <= 1'b0;
              r_lineCnt    <= '0;
              r_lineBase   <= '0;
              r_pix        <= '0;
              r_lineActive <= 1'b0;
            end else begin
              r_skipCnt <= r_skipCnt + 8'd1;
            end
          end
        end

        ST_CAPTURE: begin
          if (w_frameStart) begin
            r_frameDone  <= 1'b1;
            r_lineBase   <= '0;
            r_pix        <= '0;
            r_lineActive <= 1'b0;
            if (Continuous && Arm) begin
              r_bank    <= ~r_bank;
              r_lineCnt <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_lineEnd && r_lineActive) begin
            // The line base stops at the end of the bank, so that later
            // lines drop their pixels instead of wrapping the address.
            r_lineActive <= 1'b0;
            r_pix        <= '0;
            if (r_lineCnt != 16'hFFFF) begin
              r_lineCnt <= r_lineCnt + 16'd1;
            end
            if (w_baseInBank) begin
              r_lineBase <= r_lineBase + STRIDE_BASE;
            end
          end else if (w_pixValid) begin
            r_lineActive <= 1'b1;
            if (w_pixFits) begin
              r_pix <= r_pix + PIX_CW'(1);
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // SRAM output stage. Address, data and strobe are registered together so
  // that they always stay aligned. Address and data keep their last written
  // values between strobes.
  always_ff @(posedge DDT_Clock) begin
    if (Reset) begin
      SRAM_Addr <= '0;
      SRAM_Data <= '0;
      SRAM_WE_n <= 1'b1;
    end else begin
      SRAM_WE_n <= ~r_wrReq;
      if (r_wrReq) begin
        SRAM_Addr <= r_wrAddr;
        SRAM_Data <= r_wrData;
      end
    end
  end

  assign SRAM_CE_n  = (r_state == ST_IDLE);
  assign Busy       = (r_state != ST_IDLE);
  assign Line_Cnt   = r_lineCnt;
  assign Bank       = r_bank;
  assign Frame_Done = r_frameDone;
  assign Overflow   = r_overflow;

endmodule

// File: tb/tb_ddt_frame_capture_writer.sv
// ---------------------------------------------------------------------------
// tb_ddt_frame_capture_writer
//
// Purpose:
//   Drives randomised DDT frames into ddt_frame_capture_writer. A
//   frame-level reference model predicts every SRAM write (address, data and
//   arrival cycle). It also predicts every frame-done pulse and the status
//   outputs at each frame boundary. A monitor process matches the writes and
//   pulses that the DUT produces against the queued expectations.
// ---------------------------------------------------------------------------
module tb_ddt_frame_capture_writer;

  localparam int PIX_W       = 8;
  localparam int ADDR_W      = 8;
  localparam int LINE_STRIDE = 16;
  localparam int SKIP_FRAMES = 1;
  localparam int BANK_WORDS  = 1 << (ADDR_W - 1);

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_CAPT = 2;

  logic                clk = 1'b0;
  logic                Reset;
  logic                Arm;
  logic                Continuous;
  logic                DDT_VSA_Inv;
  logic                DDT_DE;
  logic [PIX_W-1:0]    DDT_R;
  logic [PIX_W-1:0]    DDT_G;
  logic [PIX_W-1:0]    DDT_B;
  logic [ADDR_W-1:0]   SRAM_Addr;
  logic [3*PIX_W-1:0]  SRAM_Data;
  logic                SRAM_WE_n;
  logic                SRAM_CE_n;
  logic [15:0]         Line_Cnt;
  logic                Bank;
  logic                Busy;
  logic                Frame_Done;
  logic                Overflow;

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;

  // Scoreboard: one entry per predicted write, plus a count of the
  // frame-done pulses that are still owed.
  int expAddr[$];
  int expData[$];
  int expCyc[$];
  int expDone = 0;

  // Frame-level reference model state.
  int mMode    = M_IDLE;
  int mSkip    = 0;
  int mBank    = 0;
  int mLineCnt = 0;
  int mBase    = 0;
  int mOvf     = 0;

  ddt_frame_capture_writer #(
    .PIX_W       (PIX_W),
    .ADDR_W      (ADDR_W),
    .LINE_STRIDE (LINE_STRIDE),
    .SKIP_FRAMES (SKIP_FRAMES)
  ) dut (
    .DDT_Clock   (clk),
    .Reset       (Reset),
    .Arm         (Arm),
    .Continuous  (Continuous),
    .DDT_VSA_Inv (DDT_VSA_Inv),
    .DDT_DE      (DDT_DE),
    .DDT_R       (DDT_R),
    .DDT_G       (DDT_G),
    .DDT_B       (DDT_B),
    .SRAM_Addr   (SRAM_Addr),
    .SRAM_Data   (SRAM_Data),
    .SRAM_WE_n   (SRAM_WE_n),
    .SRAM_CE_n   (SRAM_CE_n),
    .Line_Cnt    (Line_Cnt),
    .Bank        (Bank),
    .Busy        (Busy),
    .Frame_Done  (Frame_Done),
    .Overflow    (Overflow)
  );

  always #5 clk = ~clk;

  // Count rising edges. A value read #1 after an edge is that edge's number.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Monitor: match every DUT write and frame-done pulse against the
  // scoreboard. Sampling is done on the falling edge.
  always @(negedge clk) begin
    if (!Reset) begin
      if (SRAM_WE_n == 1'b0) begin
        if (expAddr.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr %0d, expected no write", SRAM_Addr);
        end else begin
          checkOutput("write_addr",  int'(SRAM_Addr), expAddr.pop_front());
          checkOutput("write_data",  int'(SRAM_Data), expData.pop_front());
          checkOutput("write_cycle", cycleCnt,        expCyc.pop_front());
        end
      end
      if (Frame_Done) begin
        checks++;
        if (expDone == 0) begin
          failures++;
          $display("[TB] FAIL frame_done: got pulse, expected none");
        end else begin
          expDone--;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model of arming: leaving IDLE clears the overflow flag, and dropping
  // Arm while waiting for a frame returns to IDLE.
  task automatic modelArm();
    if (Arm && mMode == M_IDLE) begin
      mMode = M_WAIT;
      mSkip = 0;
      mOvf  = 0;
    end else if (!Arm && mMode == M_WAIT) begin
      mMode = M_IDLE;
    end
  endtask

  task automatic setArm(input logic a);
    Arm = a;
    modelArm();
    tick(3);
  endtask

  task automatic checkStatus();
    checkOutput("line_cnt",       int'(Line_Cnt),  mLineCnt);
    checkOutput("bank",           int'(Bank),      mBank);
    checkOutput("busy",           int'(Busy),      (mMode != M_IDLE) ? 1 : 0);
    checkOutput("ce_n",           int'(SRAM_CE_n), (mMode == M_IDLE) ? 1 : 0);
    checkOutput("overflow",       int'(Overflow),  mOvf);
    checkOutput("pending_writes", expAddr.size(),  0);
  endtask

  // Send one line of n pixels. If armAt >= 0, Arm is raised on that pixel.
  task automatic applyStimulus(input int n, input int armAt);
    int sum;
    for (int p = 0; p < n; p++) begin
      if (p == armAt) begin
        Arm = 1'b1;
        modelArm();
      end
      DDT_DE = 1'b1;
      DDT_R  = 8'($urandom);
      DDT_G  = 8'($urandom);
      DDT_B  = 8'($urandom);
      if (mMode == M_CAPT) begin
        sum = mBase + p;
        if (p >= LINE_STRIDE || sum >= BANK_WORDS) begin
          mOvf = 1;
        end else begin
          expAddr.push_back(mBank * BANK_WORDS + sum);
          expData.push_back(int'({DDT_B, DDT_G, DDT_R}));
          expCyc.push_back(cycleCnt + 3);
        end
      end
      tick(1);
    end
    DDT_DE = 1'b0;
    if (mMode == M_CAPT) begin
      if (mLineCnt < 65535) mLineCnt++;
      mBase += LINE_STRIDE;
    end
    tick(3 + int'($urandom_range(0, 3)));
  endtask

  task automatic frameStart();
    checkStatus();
    DDT_VSA_Inv = 1'b0;
    tick(2);
    DDT_VSA_Inv = 1'b1;
    if (mMode == M_WAIT) begin
      if (mSkip == SKIP_FRAMES) begin
        mMode    = M_CAPT;
        mBank    = 0;
        mLineCnt = 0;
        mBase    = 0;
      end else begin
        mSkip++;
      end
    end else if (mMode == M_CAPT) begin
      expDone++;
      mBase = 0;
      if (Continuous && Arm) begin
        mBank    = 1 - mBank;
        mLineCnt = 0;
      end else begin
        mMode = M_IDLE;
      end
    end
    modelArm();
    tick(3);
  endtask

  task automatic randomFrame(input int nLines);
    frameStart();
    for (int l = 0; l < nLines; l++) applyStimulus(int'($urandom_range(1, 20)), -1);
  endtask

  initial begin
    Reset       = 1'b1;
    Arm         = 1'b0;
    Continuous  = 1'b0;
    DDT_VSA_Inv = 1'b1;
    DDT_DE      = 1'b0;
    DDT_R       = '0;
    DDT_G       = '0;
    DDT_B       = '0;
    tick(3);
    checkOutput("rst_we_n",       int'(SRAM_WE_n),  1);
    checkOutput("rst_ce_n",       int'(SRAM_CE_n),  1);
    checkOutput("rst_addr",       int'(SRAM_Addr),  0);
    checkOutput("rst_data",       int'(SRAM_Data),  0);
    checkOutput("rst_busy",       int'(Busy),       0);
    checkOutput("rst_frame_done", int'(Frame_Done), 0);
    Reset = 1'b0;
    tick(2);

    // Arm in the middle of a line, skip one frame, capture one frame of
    // 4 lines x 8 pixels, then close the frame without re-arming.
    applyStimulus(8, 3);
    frameStart();
    for (int l = 0; l < 4; l++) applyStimulus(8, -1);
    frameStart();
    for (int l = 0; l < 4; l++) applyStimulus(8, -1);
    setArm(1'b0);
    frameStart();
    applyStimulus(8, -1);
    checkOutput("single_shot_lines", int'(Line_Cnt), 4);
    checkOutput("single_shot_idle",  int'(Busy),     0);

    // Continuous ping-pong capture over three frames, one line of them long.
    Continuous = 1'b1;
    setArm(1'b1);
    frameStart();
    for (int f = 0; f < 3; f++) begin
      frameStart();
      applyStimulus(20, -1);
      for (int l = 0; l < 3; l++) applyStimulus(int'($urandom_range(1, 16)), -1);
    end
    Continuous = 1'b0;
    frameStart();
    setArm(1'b0);

    // Random arm/continuous patterns. Frames of up to 9 lines run off the
    // end of the bank.
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 2) == 0) setArm(~Arm);
      Continuous = 1'($urandom_range(0, 1));
      randomFrame(int'($urandom_range(1, 9)));
    end

    // Reset while capturing into bank 1 with Overflow set.
    Continuous = 1'b1;
    setArm(1'b1);
    for (int k = 0; k < 8 && !(mMode == M_CAPT && mBank == 1); k++) begin
      frameStart();
      applyStimulus(4, -1);
    end
    applyStimulus(20, -1);
    checkStatus();
    Reset = 1'b1;
    tick(3);
    mMode    = M_IDLE;
    mBank    = 0;
    mLineCnt = 0;
    mBase    = 0;
    mOvf     = 0;
    checkOutput("midrst_we_n",     int'(SRAM_WE_n), 1);
    checkOutput("midrst_ce_n",     int'(SRAM_CE_n), 1);
    checkOutput("midrst_busy",     int'(Busy),      0);
    checkOutput("midrst_bank",     int'(Bank),      0);
    checkOutput("midrst_overflow", int'(Overflow),  0);
    checkOutput("midrst_line_cnt", int'(Line_Cnt),  0);
    Reset      = 1'b0;
    Arm        = 1'b0;
    Continuous = 1'b0;
    tick(4);

    checkOutput("writes_outstanding",     expAddr.size(), 0);
    checkOutput("frame_done_outstanding", expDone,        0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
